// File: rtl/dmem_lsu.sv
// Word-organised data RAM with an RV32I load/store front end, valid/ready
// request handshake and a response delayed by LATENCY cycles.
//
// state | meaning
// IDLE  | ready, no response pending
// WAIT  | response pending, down-counter running to terminal count 0
// RESP  | rsp_valid strobe; a new request may be accepted in this cycle
module dmem_lsu #(
    parameter int    DEPTH         = 1024,
    parameter int    LATENCY       = 1,
    parameter string MEM_INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if (LATENCY < 1 || LATENCY > 4) begin : g_latency_check
        $error("dmem_lsu: LATENCY must be in 1..4");
    end

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] mem [DEPTH];

    logic          accept, bad_f3, misalign, out_of_range, acc_err;
    logic          is_half, is_word;
    logic [1:0]    lane;
    logic [AW-1:0] idx;
    logic [31:0]   rd_word, load_data, st_data;
    logic [7:0]    rd_byte;
    logic [15:0]   rd_half;
    logic [3:0]    st_be;

    // Power-up contents only; reset never touches the array.
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    end

    assign accept       = req_valid && req_ready;
    assign lane         = req_addr[1:0];
    assign idx          = req_addr[AW+1:2];
    assign is_half      = (req_funct3[1:0] == 2'b01);
    assign is_word      = (req_funct3[1:0] == 2'b10);
    assign bad_f3       = (req_funct3[1:0] == 2'b11) || (req_funct3 == 3'b110) ||
                          (req_we && req_funct3[2]);
    assign misalign     = (is_half && lane[0]) || (is_word && (lane != 2'b00));
    assign out_of_range = ({2'b00, req_addr[31:2]} >= 32'(DEPTH));
    assign acc_err      = bad_f3 || misalign || out_of_range;

    assign rd_word = mem[idx];
    assign rd_byte = rd_word[8*lane +: 8];
    assign rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        load_data = '0;
        case (req_funct3)
            3'b000:  load_data = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
            3'b010:  load_data = rd_word;
            3'b100:  load_data = {24'h0, rd_byte};
            3'b101:  load_data = {16'h0, rd_half};
            default: load_data = '0;
        endcase
    end

    // Replicate narrow store data so every enabled lane sees the right bytes.
    always_comb begin
        st_be   = 4'b0000;
        st_data = req_wdata;
        case (req_funct3[1:0])
            2'b00: begin
                st_be   = 4'b0001 << lane;
                st_data = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                st_be   = lane[1] ? 4'b1100 : 4'b0011;
                st_data = {2{req_wdata[15:0]}};
            end
            2'b10:   st_be = 4'b1111;
            default: st_be = 4'b0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept && req_we && !acc_err) begin
            for (int b = 0; b < 4; b++) begin
                if (st_be[b]) mem[idx][8*b +: 8] <= st_data[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                rsp_rdata <= (acc_err || req_we) ? 32'h0 : load_data;
                rsp_err   <= acc_err;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, RESP: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 2'(LATENCY - 2);
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q == 2'd0) state_d = RESP;
                else               cnt_d   = cnt_q - 2'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_ready = (state_q != WAIT);
    assign rsp_valid = (state_q == RESP);

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu: one instance at LATENCY 1, one at LATENCY 3,
// sharing clock and reset.
module tb_dmem_lsu;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [1:0]  req_valid;
    logic [1:0]  req_we;
    logic [2:0]  req_funct3 [2];
    logic [31:0] req_addr   [2];
    logic [31:0] req_wdata  [2];
    wire  [1:0]  req_ready;
    wire  [1:0]  rsp_valid;
    wire  [1:0]  rsp_err;
    wire  [31:0] rsp_rdata  [2];

    int n_checks = 0;
    int n_errors = 0;
    int seen;

    always #5 clk = ~clk;

    dmem_lsu #(.DEPTH(1024), .LATENCY(1)) u_lat1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_funct3(req_funct3[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    dmem_lsu #(.DEPTH(1024), .LATENCY(3)) u_lat3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_funct3(req_funct3[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Full transaction: hold request until accepted, then wait for the strobe.
    task automatic access(input int d, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rd, input logic exp_err,
                          input string tag);
        int n;
        int lat;
        @(negedge clk);
        req_valid[d]  = 1'b1;
        req_we[d]     = we;
        req_funct3[d] = f3;
        req_addr[d]   = addr;
        req_wdata[d]  = wdata;
        n = 0;
        while (req_ready[d] !== 1'b1 && n < 16) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " accept"}, 32'(n < 16), 32'd1);
        @(posedge clk);
        #1 req_valid[d] = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (rsp_valid[d] !== 1'b1 && lat < 10);
        chk({tag, " latency"}, 32'(lat), (d == 0) ? 32'd1 : 32'd3);
        chk({tag, " rdata"}, rsp_rdata[d], exp_rd);
        chk({tag, " err"}, {31'h0, rsp_err[d]}, {31'h0, exp_err});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        req_valid = '0;
        req_we    = '0;
        for (int i = 0; i < 2; i++) begin
            req_funct3[i] = 3'b000;
            req_addr[i]   = '0;
            req_wdata[i]  = '0;
        end

        // Reset behaviour
        #1;
        chk("rst ready0", {31'h0, req_ready[0]}, 32'd1);
        chk("rst valid0", {31'h0, rsp_valid[0]}, 32'd0);
        chk("rst ready1", {31'h0, req_ready[1]}, 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post rst ready0", {31'h0, req_ready[0]}, 32'd1);
        chk("post rst valid0", {31'h0, rsp_valid[0]}, 32'd0);
        chk("post rst rdata0", rsp_rdata[0], 32'h0);
        access(0, 1'b0, 3'b010, 32'h0, 32'h0, 32'h0000_0000, 1'b0, "lw0 init");

        // Loads of each size/sign after a word store
        access(0, 1'b1, 3'b010, 32'h4, 32'hDEAD_BEEF, 32'h0, 1'b0, "sw4");
        access(0, 1'b0, 3'b000, 32'h4, 32'h0, 32'hFFFF_FFEF, 1'b0, "lb4");
        access(0, 1'b0, 3'b100, 32'h7, 32'h0, 32'h0000_00DE, 1'b0, "lbu7");
        access(0, 1'b0, 3'b001, 32'h6, 32'h0, 32'hFFFF_DEAD, 1'b0, "lh6");
        access(0, 1'b0, 3'b101, 32'h4, 32'h0, 32'h0000_BEEF, 1'b0, "lhu4");

        // Partial stores keep the other lanes
        access(0, 1'b1, 3'b000, 32'h5, 32'hAAAA_AA55, 32'h0, 1'b0, "sb5");
        access(0, 1'b0, 3'b010, 32'h4, 32'h0, 32'hDEAD_55EF, 1'b0, "lw4 after sb");
        access(0, 1'b1, 3'b001, 32'h6, 32'hFFFF_1234, 32'h0, 1'b0, "sh6");
        access(0, 1'b0, 3'b010, 32'h4, 32'h0, 32'h1234_55EF, 1'b0, "lw4 after sh");
        access(0, 1'b0, 3'b001, 32'h4, 32'h0, 32'h0000_55EF, 1'b0, "lh4 positive");
        access(0, 1'b0, 3'b000, 32'h5, 32'h0, 32'h0000_0055, 1'b0, "lb5 positive");

        // Error cases leave memory untouched
        access(0, 1'b0, 3'b010, 32'h2, 32'h0, 32'h0, 1'b1, "lw misaligned");
        access(0, 1'b1, 3'b001, 32'h9, 32'h5555_5555, 32'h0, 1'b1, "sh misaligned");
        access(0, 1'b0, 3'b011, 32'h0, 32'h0, 32'h0, 1'b1, "load f3 011");
        access(0, 1'b0, 3'b110, 32'h4, 32'h0, 32'h0, 1'b1, "load f3 110");
        access(0, 1'b1, 3'b100, 32'h4, 32'h0BAD_0BAD, 32'h0, 1'b1, "store f3 100");
        access(0, 1'b1, 3'b010, 32'h5, 32'h0BAD_0BAD, 32'h0, 1'b1, "sw misaligned");
        access(0, 1'b1, 3'b010, 32'h1000, 32'hCAFE_BABE, 32'h0, 1'b1, "sw out of range");
        access(0, 1'b0, 3'b010, 32'h1000, 32'h0, 32'h0, 1'b1, "lw out of range");
        access(0, 1'b0, 3'b010, 32'h0, 32'h0, 32'h0000_0000, 1'b0, "lw0 unchanged");
        access(0, 1'b0, 3'b010, 32'h4, 32'h0, 32'h1234_55EF, 1'b0, "lw4 unchanged");
        access(0, 1'b0, 3'b010, 32'hFFC, 32'h0, 32'h0, 1'b0, "lw last word");

        // LATENCY 3: timing, and a request held through WAIT taken in RESP
        @(negedge clk);
        req_valid[1] = 1'b1; req_we[1] = 1'b1; req_funct3[1] = 3'b010;
        req_addr[1] = 32'h10; req_wdata[1] = 32'h1122_3344;
        chk("l3 idle ready", {31'h0, req_ready[1]}, 32'd1);
        @(posedge clk);
        #1 begin
            req_we[1] = 1'b0; req_addr[1] = 32'h10; req_wdata[1] = 32'h0;
        end
        @(negedge clk);
        chk("l3 wait1 ready", {31'h0, req_ready[1]}, 32'd0);
        chk("l3 wait1 valid", {31'h0, rsp_valid[1]}, 32'd0);
        @(negedge clk);
        chk("l3 wait2 ready", {31'h0, req_ready[1]}, 32'd0);
        chk("l3 wait2 valid", {31'h0, rsp_valid[1]}, 32'd0);
        @(negedge clk);
        chk("l3 resp valid", {31'h0, rsp_valid[1]}, 32'd1);
        chk("l3 resp ready", {31'h0, req_ready[1]}, 32'd1);
        chk("l3 sw err", {31'h0, rsp_err[1]}, 32'd0);
        chk("l3 sw rdata", rsp_rdata[1], 32'h0);
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
        @(negedge clk);
        chk("l3 held req taken", {31'h0, req_ready[1]}, 32'd0);
        chk("l3 no early valid", {31'h0, rsp_valid[1]}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("l3 lw valid", {31'h0, rsp_valid[1]}, 32'd1);
        chk("l3 lw rdata", rsp_rdata[1], 32'h1122_3344);
        access(1, 1'b0, 3'b001, 32'h12, 32'h0, 32'h0000_1122, 1'b0, "l3 lh12");

        // LATENCY 3: reset during WAIT drops the response
        @(negedge clk);
        req_valid[1] = 1'b1; req_we[1] = 1'b0; req_funct3[1] = 3'b010; req_addr[1] = 32'h10;
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
        @(negedge clk);
        chk("l3 pre-rst in wait", {31'h0, req_ready[1]}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("l3 rst ready", {31'h0, req_ready[1]}, 32'd1);
        chk("l3 rst valid", {31'h0, rsp_valid[1]}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (rsp_valid[1] === 1'b1) seen++;
        end
        chk("l3 dropped rsp", 32'(seen), 32'd0);
        access(1, 1'b0, 3'b010, 32'h10, 32'h0, 32'h1122_3344, 1'b0, "l3 sw survives rst");
        access(0, 1'b0, 3'b010, 32'h4, 32'h0, 32'h1234_55EF, 1'b0, "l1 mem survives rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
